// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port among NUM_REQ requesters, with serial-tagged response routing.
// Grant is combinational (same cycle); requesters stall while memory is busy or the next serial's slot is still live.
module mem_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int RSERIAL_W = 4,
  parameter int WSERIAL_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ-1:0]        reqWrite,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqWriteData,
  output logic [NUM_REQ-1:0]        reqGrant,
  output logic [ADDR_W-1:0]         memAccessAddr,
  output logic [DATA_W-1:0]         memAccessWriteData,
  output logic                      memAccessRE,
  output logic                      memAccessWE,
  input  logic                      memAccessReadBusy,
  input  logic                      memAccessWriteBusy,
  input  logic [RSERIAL_W-1:0]      nextMemReadSerial,
  input  logic [WSERIAL_W-1:0]      nextMemWriteSerial,
  input  logic                      memReadDataReady,
  input  logic [RSERIAL_W-1:0]      memReadSerial,
  input  logic [DATA_W-1:0]         memReadData,
  input  logic                      memWriteAckValid,
  input  logic [WSERIAL_W-1:0]      memWriteAckSerial,
  output logic [NUM_REQ-1:0]        rspReadValid,
  output logic [DATA_W-1:0]         rspReadData,
  output logic [NUM_REQ-1:0]        rspWriteDone,
  output logic [RSERIAL_W:0]        outstandingReads,
  output logic                      orphanError
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RSLOTS = 1 << RSERIAL_W;
  localparam int WSLOTS = 1 << WSERIAL_W;
  typedef logic [IDX_W-1:0] idx_t;

  logic [RSLOTS-1:0] rd_valid_q, rd_valid_d;
  idx_t              rd_owner_q [RSLOTS];
  idx_t              rd_owner_d [RSLOTS];
  logic [WSLOTS-1:0] wr_valid_q, wr_valid_d;
  idx_t              wr_owner_q [WSLOTS];
  idx_t              wr_owner_d [WSLOTS];
  idx_t              rr_ptr_q, rr_ptr_d;
  logic [RSERIAL_W:0] rd_count_q, rd_count_d;
  logic              orphan_q, orphan_d;

  logic [NUM_REQ-1:0] elig;
  logic               rd_ok, wr_ok, win_vld;
  idx_t               win_idx;
  logic [IDX_W:0]     scan;
  logic               rd_hit, wr_hit, rd_orphan, wr_orphan;

  // Gating with rst keeps every output at zero while reset is held.
  always_comb begin
    rd_ok   = rst && !memAccessReadBusy && !rd_valid_q[nextMemReadSerial];
    wr_ok   = rst && !memAccessWriteBusy && !wr_valid_q[nextMemWriteSerial];
    elig    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = reqValid[i] && (reqWrite[i] ? wr_ok : rd_ok);
    end
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ)) scan = scan - (IDX_W+1)'(NUM_REQ);
      if (!win_vld && elig[scan[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    reqGrant           = '0;
    memAccessAddr      = '0;
    memAccessWriteData = '0;
    memAccessRE        = 1'b0;
    memAccessWE        = 1'b0;
    if (win_vld) begin
      reqGrant[win_idx]  = 1'b1;
      memAccessAddr      = reqAddr[win_idx*ADDR_W +: ADDR_W];
      memAccessWriteData = reqWriteData[win_idx*DATA_W +: DATA_W];
      memAccessRE        = !reqWrite[win_idx];
      memAccessWE        = reqWrite[win_idx];
    end
  end

  always_comb begin
    rd_hit       = rst && memReadDataReady && rd_valid_q[memReadSerial];
    rd_orphan    = rst && memReadDataReady && !rd_valid_q[memReadSerial];
    wr_hit       = rst && memWriteAckValid && wr_valid_q[memWriteAckSerial];
    wr_orphan    = rst && memWriteAckValid && !wr_valid_q[memWriteAckSerial];
    rspReadValid = '0;
    rspWriteDone = '0;
    if (rd_hit) rspReadValid[rd_owner_q[memReadSerial]] = 1'b1;
    if (wr_hit) rspWriteDone[wr_owner_q[memWriteAckSerial]] = 1'b1;
    rspReadData      = rst ? memReadData : '0;
    outstandingReads = rd_count_q;
    orphanError      = orphan_q;
  end

  // An issue slot can never equal the returning slot: issue requires the slot to be free.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_owner_d = rd_owner_q;
    wr_valid_d = wr_valid_q;
    wr_owner_d = wr_owner_q;
    if (rd_hit) rd_valid_d[memReadSerial] = 1'b0;
    if (wr_hit) wr_valid_d[memWriteAckSerial] = 1'b0;
    if (memAccessRE) begin
      rd_valid_d[nextMemReadSerial] = 1'b1;
      rd_owner_d[nextMemReadSerial] = win_idx;
    end
    if (memAccessWE) begin
      wr_valid_d[nextMemWriteSerial] = 1'b1;
      wr_owner_d[nextMemWriteSerial] = win_idx;
    end
    rd_count_d = rd_count_q + {{RSERIAL_W{1'b0}}, memAccessRE} - {{RSERIAL_W{1'b0}}, rd_hit};
    orphan_d   = orphan_q | rd_orphan | wr_orphan;
    rr_ptr_d   = rr_ptr_q;
    if (win_vld) rr_ptr_d = (win_idx == idx_t'(NUM_REQ-1)) ? '0 : win_idx + idx_t'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= '0;
      rd_owner_q <= '{default: '0};
      wr_valid_q <= '0;
      wr_owner_q <= '{default: '0};
      rr_ptr_q   <= '0;
      rd_count_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      wr_valid_q <= wr_valid_d;
      wr_owner_q <= wr_owner_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_count_q <= rd_count_d;
      orphan_q   <= orphan_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after posedge, outputs checked at the following negedge.
module tb_mem_port_arbiter;
  localparam int NR = 3, AW = 32, DW = 128, RSW = 4, WSW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   reqValid, reqWrite;
  logic [NR*AW-1:0] reqAddr;
  logic [NR*DW-1:0] reqWriteData;
  logic [NR-1:0]   reqGrant;
  logic [AW-1:0]   memAccessAddr;
  logic [DW-1:0]   memAccessWriteData;
  logic            memAccessRE, memAccessWE;
  logic            memAccessReadBusy, memAccessWriteBusy;
  logic [RSW-1:0]  nextMemReadSerial, memReadSerial;
  logic [WSW-1:0]  nextMemWriteSerial, memWriteAckSerial;
  logic            memReadDataReady, memWriteAckValid;
  logic [DW-1:0]   memReadData, rspReadData;
  logic [NR-1:0]   rspReadValid, rspWriteDone;
  logic [RSW:0]    outstandingReads;
  logic            orphanError;

  logic [AW-1:0] addr_of [NR];
  logic [DW-1:0] data_of [NR];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RSERIAL_W(RSW), .WSERIAL_W(WSW)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWriteData(reqWriteData),
    .reqGrant(reqGrant), .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
    .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
    .memAccessReadBusy(memAccessReadBusy), .memAccessWriteBusy(memAccessWriteBusy),
    .nextMemReadSerial(nextMemReadSerial), .nextMemWriteSerial(nextMemWriteSerial),
    .memReadDataReady(memReadDataReady), .memReadSerial(memReadSerial), .memReadData(memReadData),
    .memWriteAckValid(memWriteAckValid), .memWriteAckSerial(memWriteAckSerial),
    .rspReadValid(rspReadValid), .rspReadData(rspReadData), .rspWriteDone(rspWriteDone),
    .outstandingReads(outstandingReads), .orphanError(orphanError)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      addr_of[i] = 32'h1000_0000 + 32'h100 * i;
      data_of[i] = {4{32'hC0DE_0000 + 32'(i)}};
      reqAddr[i*AW +: AW]      = addr_of[i];
      reqWriteData[i*DW +: DW] = data_of[i];
    end
    rst = 1'b0;
    reqValid = '1; reqWrite = '0;
    memAccessReadBusy = 1'b0; memAccessWriteBusy = 1'b0;
    nextMemReadSerial = '0; nextMemWriteSerial = '0;
    memReadDataReady = 1'b1; memReadSerial = '0; memReadData = 128'h55;
    memWriteAckValid = 1'b1; memWriteAckSerial = '0;
    #3;
    // Reset holds every output low regardless of inputs
    check("rst_grant", 128'(reqGrant), 128'(3'b000));
    check("rst_re_we", 128'({memAccessRE, memAccessWE}), 128'(2'b00));
    check("rst_count", 128'(outstandingReads), 128'(0));
    check("rst_rsp",   128'({rspReadValid, rspWriteDone}), 128'(0));
    check("rst_rdata", 128'(rspReadData), 128'(0));
    check("rst_orphan", 128'(orphanError), 128'(0));
    step();
    memReadDataReady = 1'b0; memWriteAckValid = 1'b0;
    step();
    rst = 1'b1;
    settle();
    check("first_grant", 128'(reqGrant), 128'(3'b001));
    check("first_re", 128'({memAccessRE, memAccessWE}), 128'(2'b10));
    check("first_addr", 128'(memAccessAddr), 128'(addr_of[0]));

    step(); reqValid = 3'b110; nextMemReadSerial = 4'd1; settle();
    check("rr_grant1", 128'(reqGrant), 128'(3'b010));
    check("rr_addr1", 128'(memAccessAddr), 128'(addr_of[1]));
    step(); reqValid = 3'b100; nextMemReadSerial = 4'd2; settle();
    check("rr_grant2", 128'(reqGrant), 128'(3'b100));
    step(); reqValid = 3'b000; memReadDataReady = 1'b1; memReadSerial = 4'd1;
    memReadData = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; settle();
    check("count3", 128'(outstandingReads), 128'(3));
    check("ret_s1_rsp", 128'(rspReadValid), 128'(3'b010));
    check("ret_s1_data", 128'(rspReadData), 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check("idle_grant", 128'(reqGrant), 128'(0));
    step(); memReadSerial = 4'd0; settle();
    check("ret_s0_rsp", 128'(rspReadValid), 128'(3'b001));
    check("count2", 128'(outstandingReads), 128'(2));
    step(); memReadSerial = 4'd2; settle();
    check("ret_s2_rsp", 128'(rspReadValid), 128'(3'b100));
    step(); memReadDataReady = 1'b0; settle();
    check("count0", 128'(outstandingReads), 128'(0));

    // Write held off by busy; read from req2 goes first
    reqValid = 3'b110; reqWrite = 3'b010; memAccessWriteBusy = 1'b1;
    nextMemWriteSerial = 4'd3; nextMemReadSerial = 4'd4; settle();
    check("busy_rd_grant", 128'(reqGrant), 128'(3'b100));
    check("busy_rd_addr", 128'(memAccessAddr), 128'(addr_of[2]));
    for (int c = 0; c < 3; c++) begin
      step(); reqValid = 3'b010; settle();
      check("wbusy_block", 128'(reqGrant), 128'(0));
    end
    step(); memAccessWriteBusy = 1'b0; settle();
    check("wr_grant", 128'(reqGrant), 128'(3'b010));
    check("wr_re_we", 128'({memAccessRE, memAccessWE}), 128'(2'b01));
    check("wr_data", 128'(memAccessWriteData), 128'(data_of[1]));
    check("wr_addr", 128'(memAccessAddr), 128'(addr_of[1]));
    step(); reqValid = 3'b000; reqWrite = 3'b000;
    memWriteAckValid = 1'b1; memWriteAckSerial = 4'd3;
    memReadDataReady = 1'b1; memReadSerial = 4'd4; settle();
    check("wr_ack_done", 128'(rspWriteDone), 128'(3'b010));
    check("ret_s4_rsp", 128'(rspReadValid), 128'(3'b100));
    step(); memWriteAckValid = 1'b0; memReadDataReady = 1'b0; settle();
    check("ack_clear", 128'(rspWriteDone), 128'(0));
    check("count0b", 128'(outstandingReads), 128'(0));

    // Occupied read slot blocks reads but not writes
    reqValid = 3'b001; nextMemReadSerial = 4'd5; settle();
    check("s5_grant", 128'(reqGrant), 128'(3'b001));
    step(); reqValid = 3'b011; reqWrite = 3'b010; nextMemWriteSerial = 4'd7; settle();
    check("slot_busy_grant", 128'(reqGrant), 128'(3'b010));
    check("slot_busy_re_we", 128'({memAccessRE, memAccessWE}), 128'(2'b01));
    check("count1", 128'(outstandingReads), 128'(1));
    step(); reqValid = 3'b001; reqWrite = 3'b000; nextMemReadSerial = 4'd6;
    memReadDataReady = 1'b1; memReadSerial = 4'd5; settle();
    check("same_cyc_grant", 128'(reqGrant), 128'(3'b001));
    check("same_cyc_rsp", 128'(rspReadValid), 128'(3'b001));
    step(); reqValid = 3'b000; memReadDataReady = 1'b0;
    memWriteAckValid = 1'b1; memWriteAckSerial = 4'd7; settle();
    check("same_cyc_count", 128'(outstandingReads), 128'(1));
    check("ack7_done", 128'(rspWriteDone), 128'(3'b010));
    step(); memWriteAckValid = 1'b0; memReadDataReady = 1'b1; memReadSerial = 4'd6; settle();
    check("ret_s6_rsp", 128'(rspReadValid), 128'(3'b001));
    step(); memReadDataReady = 1'b0; settle();
    check("count0c", 128'(outstandingReads), 128'(0));
    check("no_orphan", 128'(orphanError), 128'(0));

    // Orphan return on a never-issued serial
    memReadDataReady = 1'b1; memReadSerial = 4'd9; settle();
    check("orphan_rsp", 128'(rspReadValid), 128'(0));
    step(); memReadDataReady = 1'b0; settle();
    check("orphan_set", 128'(orphanError), 128'(1));
    step(); step(); settle();
    check("orphan_sticky", 128'(orphanError), 128'(1));
    check("orphan_count", 128'(outstandingReads), 128'(0));

    // Reset with four reads outstanding
    reqValid = 3'b001; reqWrite = 3'b000; nextMemReadSerial = 4'd0; settle();
    check("r4_grant0", 128'(reqGrant), 128'(3'b001));
    for (int s = 1; s < 4; s++) begin
      step(); nextMemReadSerial = RSW'(s); settle();
      check("r4_grant", 128'(reqGrant), 128'(3'b001));
    end
    step(); reqValid = 3'b000; settle();
    check("count4", 128'(outstandingReads), 128'(4));
    step(); rst = 1'b0; reqValid = 3'b111; settle();
    check("mid_rst_count", 128'(outstandingReads), 128'(0));
    check("mid_rst_orphan", 128'(orphanError), 128'(0));
    check("mid_rst_grant", 128'(reqGrant), 128'(0));
    step(); rst = 1'b1; reqValid = 3'b000;
    step(); memReadDataReady = 1'b1; memReadSerial = 4'd0; settle();
    check("post_rst_rsp", 128'(rspReadValid), 128'(0));
    step(); memReadDataReady = 1'b0; settle();
    check("post_rst_orphan", 128'(orphanError), 128'(1));
    check("post_rst_count", 128'(outstandingReads), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
